// File: rtl/mips_cpu_fetch_pc.sv
// MIPS fetch program counter with one-deep branch delay slot handling.
// Halts on a fetch of address zero or on a misaligned redirect target.
module mips_cpu_fetch_pc #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] instr_address,
    output logic [31:0] pc_link,
    output logic        delay_slot,
    output logic        active,
    output logic        addr_error,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        SLOT = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_target;
    logic        r_delay_slot;
    logic        r_active;
    logic        r_addr_error;
    logic [31:0] w_pc_plus4;

    assign w_pc_plus4 = r_pc + 32'd4;

    // Redirect handshake: redirect_valid has no ready; it is accepted only on an
    // enabled edge in RUN. Redirects seen in SLOT, HALT or during a stall are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= RUN;
            r_pc         <= RESET_VECTOR;
            r_target     <= 32'd0;
            r_delay_slot <= 1'b0;
            r_active     <= 1'b1;
            r_addr_error <= 1'b0;
        end else if (clk_enable && r_state != HALT) begin
            case (r_state)
                RUN: begin
                    r_pc <= w_pc_plus4;
                    if (w_pc_plus4 == 32'd0) begin
                        r_state  <= HALT;
                        r_active <= 1'b0;
                    end else if (redirect_valid) begin
                        r_target     <= redirect_target;
                        r_delay_slot <= 1'b1;
                        r_state      <= SLOT;
                    end
                end
                SLOT: begin
                    r_delay_slot <= 1'b0;
                    if (r_target[1:0] != 2'b00) begin
                        // Misaligned target: stay parked on the delay-slot address.
                        r_addr_error <= 1'b1;
                        r_active     <= 1'b0;
                        r_state      <= HALT;
                    end else begin
                        r_pc <= r_target;
                        if (r_target == 32'd0) begin
                            r_active <= 1'b0;
                            r_state  <= HALT;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                default: r_state <= HALT;
            endcase
        end
    end

    assign instr_address = r_pc;
    assign pc_link       = r_pc + 32'd8;
    assign delay_slot    = r_delay_slot;
    assign active        = r_active;
    assign addr_error    = r_addr_error;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_mips_cpu_fetch_pc.sv
// Randomized bench for mips_cpu_fetch_pc: a reference model pushes expected
// outputs per clock edge and a monitor pops and compares after each edge.
module tb_mips_cpu_fetch_pc;

  localparam logic [31:0] RV = 32'hBFC00000;
  localparam int EW = 67;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_enable = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic [31:0] instr_address;
  logic [31:0] pc_link;
  logic        delay_slot;
  logic        active;
  logic        addr_error;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  logic [EW-1:0] exp_q[$];

  // reference model: pc, one pending redirect, halt/error flags
  logic [31:0] m_pc;
  logic [31:0] m_tgt;
  logic        m_pending;
  logic        m_halted;
  logic        m_err;

  mips_cpu_fetch_pc #(.RESET_VECTOR(RV)) dut (
    .clk            (clk),
    .reset          (reset),
    .clk_enable     (clk_enable),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .instr_address  (instr_address),
    .pc_link        (pc_link),
    .delay_slot     (delay_slot),
    .active         (active),
    .addr_error     (addr_error),
    .dbg_state      (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  // reference model
  task automatic m_reset();
    m_pc      = RV;
    m_tgt     = 32'd0;
    m_pending = 1'b0;
    m_halted  = 1'b0;
    m_err     = 1'b0;
  endtask

  task automatic m_step(input logic en, input logic rv, input logic [31:0] tgt);
    if (m_halted || !en) return;
    if (m_pending) begin
      m_pending = 1'b0;
      if (m_tgt % 4 != 0) begin
        m_err    = 1'b1;
        m_halted = 1'b1;
      end else begin
        m_pc = m_tgt;
        if (m_pc == 0) m_halted = 1'b1;
      end
    end else begin
      m_pc = m_pc + 32'd4;
      if (m_pc == 0) m_halted = 1'b1;
      else if (rv) begin
        m_pending = 1'b1;
        m_tgt     = tgt;
      end
    end
  endtask

  function automatic logic [EW-1:0] m_pack();
    logic [31:0] link;
    link = m_pc + 32'd8;
    return {m_pc, link, m_pending, ~m_halted, m_err};
  endfunction

  // scoreboard monitor
  initial begin
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {instr_address, pc_link, delay_slot, active, addr_error};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL edge t=%0t got pc=%h link=%h ds=%b act=%b err=%b want pc=%h link=%h ds=%b act=%b err=%b",
                   $time, a[66:35], a[34:3], a[2], a[1], a[0], e[66:35], e[34:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  // directed comparison against a bench constant
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // driver tasks: called at a negedge, return at the following negedge
  task automatic cycle(input logic en, input logic rv, input logic [31:0] tgt);
    clk_enable      = en;
    redirect_valid  = rv;
    redirect_target = tgt;
    m_step(en, rv, tgt);
    exp_q.push_back(m_pack());
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pc"},   instr_address, RV);
    chk({tag, "_link"}, pc_link, RV + 32'd8);
    chk({tag, "_ds"},   {31'd0, delay_slot}, 32'd0);
    chk({tag, "_act"},  {31'd0, active}, 32'd1);
    chk({tag, "_err"},  {31'd0, addr_error}, 32'd0);
  endtask

  task automatic do_reset();
    clk_enable     = 1'b0;
    redirect_valid = 1'b0;
    reset          = 1'b1;
    m_reset();
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] t;
    int wait_cyc;
    @(negedge clk);

    // sequential fetch from the reset vector
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'd0);
    chk("seq_pc", instr_address, 32'hBFC0000C);
    chk("seq_link", pc_link, 32'hBFC00014);

    // taken branch with delay slot
    cycle(1'b1, 1'b1, 32'hBFC00100);
    chk("br_slot_pc", instr_address, 32'hBFC00010);
    chk("br_slot_ds", {31'd0, delay_slot}, 32'd1);
    cycle(1'b1, 1'b0, 32'd0);
    chk("br_tgt_pc", instr_address, 32'hBFC00100);

    // stall in the delay slot; redirects during stall dropped
    cycle(1'b1, 1'b1, 32'hBFC00200);
    for (int i = 0; i < 4; i++) cycle(1'b0, (i == 1), 32'hBFC00300);
    chk("stall_pc", instr_address, 32'hBFC00104);
    cycle(1'b1, 1'b1, 32'hBFC00500);
    chk("stall_tgt_pc", instr_address, 32'hBFC00200);

    // async reset while in SLOT
    cycle(1'b1, 1'b1, 32'hBFC00400);
    #2;
    reset = 1'b1;
    m_reset();
    #1;
    check_reset_outputs("async");
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b1, 1'b0, 32'd0);
    chk("after_async_pc", instr_address, 32'hBFC00004);

    // +4 wrap into address zero halts
    cycle(1'b1, 1'b1, 32'hFFFFFFF8);
    cycle(1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 32'd0);
    chk("wrap_link", pc_link, 32'h00000004);
    cycle(1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 32'hBFC00000);
    chk("wrap_pc", instr_address, 32'h00000000);
    chk("wrap_link_halt", pc_link, 32'h00000008);
    chk("wrap_act", {31'd0, active}, 32'd0);

    // misaligned redirect target
    do_reset();
    cycle(1'b1, 1'b1, 32'hBFC00102);
    cycle(1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 32'hBFC00100);
    chk("misal_pc", instr_address, 32'hBFC00004);
    chk("misal_err", {31'd0, addr_error}, 32'd1);

    // JR $0 halts after its delay slot
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 32'h00000000);
    chk("jr0_slot_pc", instr_address, 32'hBFC00014);
    cycle(1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 32'hBFC00100);
    cycle(1'b0, 1'b1, 32'hBFC00200);
    cycle(1'b1, 1'b0, 32'd0);
    chk("jr0_pc", instr_address, 32'h00000000);
    chk("jr0_act", {31'd0, active}, 32'd0);

    // randomized runs
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int c = 0; c < 60; c++) begin
        case ($urandom_range(0, 9))
          0:       t = 32'd0;
          1:       t = {$urandom_range(0, 32'h3FFFFFFF), 2'(32'($urandom_range(1, 3)))};
          2:       t = 32'hFFFFFFF0;
          default: t = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
        endcase
        cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, t);
      end
    end

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
